// File: rtl/stream_demux_pkg.sv
// Shared defaults and helpers for the stream demultiplexer and its channel FIFOs.
package stream_demux_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_N_CH   = 4;
    localparam int unsigned DEF_SEL_W  = 3;
    localparam int unsigned DEF_DEPTH  = 2;
    localparam int unsigned DEF_CNT_W  = 16;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        clog2 = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            clog2 = clog2 + 1;
            v = v >> 1;
        end
    endfunction

    // Occupancy count for a default-depth channel FIFO (holds 0..DEPTH).
    typedef logic [clog2(DEF_DEPTH):0] fifo_cnt_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO: push when not full, pop on valid && ready, head word always visible.
module demux_chan_fifo
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full_c,
    input  logic              ready,
    output logic              valid_c,
    output logic [DATA_W-1:0] data_c
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // Full is taken from the registered count, so a full FIFO cannot take a word in the cycle it pops.
    assign full_c  = (count == CNT_W'(DEPTH));
    assign valid_c = (count != '0);
    assign data_c  = mem[rd_ptr];
    assign do_push = push & ~full_c;
    assign do_pop  = valid_c & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N_CH stream demultiplexer: unicast by select, broadcast to all, invalid selects dropped and counted.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N_CH   = DEF_N_CH,
    parameter int unsigned SEL_W  = DEF_SEL_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic                   drop_pulse,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic [N_CH-1:0] sel_hit;
    logic [N_CH-1:0] full;
    logic [N_CH-1:0] push;
    logic            sel_ok;
    logic            sel_full;
    logic            any_full;
    logic            accept;
    logic            drop;

    // One-hot decode; selects at or above N_CH hit nothing and are treated as invalid.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
    end

    assign sel_ok   = |sel_hit;
    assign sel_full = |(sel_hit & full);
    assign any_full = |full;

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = ~any_full;
        end else if (sel_ok) begin
            in_ready = ~sel_full;
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_ok;

    always_comb begin
        push = '0;
        if (accept) begin
            push = in_bcast ? {N_CH{1'b1}} : sel_hit;
        end
    end

    for (genvar gk = 0; gk < int'(N_CH); gk++) begin : g_chan
        demux_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[gk]),
            .wr_data (in_data),
            .full_c  (full[gk]),
            .ready   (out_ready[gk]),
            .valid_c (out_valid[gk]),
            .data_c  (out_data[gk*DATA_W +: DATA_W])
        );
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
